addsub_arbiter: RTL and testbench
=================================

Name: addsub_arbiter

Overview:
Shares one 32-bit add/subtract datapath among N requesters. Subtraction is A + ~B + 1, two's complement.
- Arbitration is round-robin, one operation issued per clock.
- Each requester uses a valid/ready handshake.
- The result sits in a one-deep output register with backpressure.
- The block sits between issuing units (ALU front-ends, address generators) and the shared adder.

Parameters:
N, 4, number of requesters (2..8).
W, 32, operand/result width.
IDW, 2, width of rsp_id; must equal clog2(N), and the bench checks this.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  N  per-requester operation valid.
req_op  in  N  per-requester opcode: 0 = add (A+B), 1 = subtract (A-B).
req_a  in  N*W  packed A operands; requester i occupies bits [i*W +: W].
req_b  in  N*W  packed B operands, same packing.
req_ready  out  N  one-hot (or zero) accept strobe to the granted requester.
rsp_valid  out  1  result register holds a valid result.
rsp_ready  in  1  consumer accepts result this cycle.
rsp_data  out  W  result, modulo 2^W.
rsp_id  out  IDW  index of the requester that issued the result.
rsp_carry  out  1  carry-out; for subtract, 1 = no borrow (A >= B unsigned).
rsp_ovf  out  1  signed overflow.
op_count  out  32  total accepted operations, wraps at 2^32.

Behaviour:
- Reset (rst=1 at rising edge):
  - rsp_valid, rsp_data, rsp_id, rsp_carry, rsp_ovf and op_count all go to 0.
  - The round-robin pointer goes to 0.
  - req_ready is held 0 during the reset cycle.
  - An in-flight result is discarded, not delivered.
- slot_free = !rsp_valid || rsp_ready (combinational).
- Grant (combinational):
  - Scan req_valid starting at the pointer, ascending, wrapping modulo N.
  - The first set bit wins and is index g.
  - req_ready[g] = slot_free; all other req_ready bits are 0.
  - req_ready never depends on req_op, req_a or req_b.
- Accept: occurs when req_valid[g] && req_ready[g] at a rising edge. Next cycle:
  - rsp_data = A+B, or A+~B+1 when op=1.
  - rsp_carry = bit W of the (W+1)-bit sum.
  - rsp_ovf = (A[W-1] == B'[W-1]) && (rsp_data[W-1] != A[W-1]), where B' = B for add and ~B for subtract.
  - rsp_id = g, rsp_valid = 1.
  - pointer = (g+1) mod N.
  - op_count increments by 1.
- Latency: one cycle from accept to rsp_valid.
- Throughput: 1 op/clock while rsp_ready is held high.
- No accept with rsp_ready=1: rsp_valid goes to 0. The pointer and the data fields hold their values.
- Stall (rsp_valid && !rsp_ready):
  - All rsp_* outputs stay stable.
  - req_ready stays all 0.
  - The pointer does not move.
- Result consumed and a new op accepted in the same cycle: the register is overwritten with the new result and rsp_valid stays 1. No bubble.
- No req_valid set: no grant, and the pointer holds.
- Requesters may drop req_valid without a handshake. The block has no requester-side hold rule.
- Fairness: a continuously asserting requester waits at most N-1 accepts.
- Wrap-around: 0xFFFFFFFF + 1 gives data 0, carry 1.
- Implementation: a single shared W+1-bit adder. Operand mux is selected by g; B inversion and carry-in are selected by req_op[g].

Test Plan:
1. Single add: req0, A=0x00000005, B=0x00000003, op=0 -> next cycle rsp_valid=1, data=0x00000008, id=0, carry=0, ovf=0, op_count=1.
2. Subtract:
   - req2, A=3, B=5, op=1 -> data=0xFFFFFFFE, carry=0 (borrow), ovf=0.
   - A=0x80000000, B=1, op=1 -> data=0x7FFFFFFF, carry=1, ovf=1.
3. Round-robin: all four req_valid high, rsp_ready=1 for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3. One result per cycle; op_count=8.
4. Backpressure:
   - Accept req1; hold rsp_ready=0 for 3 cycles with req3 valid.
   - Required: rsp_data/rsp_id stable, req_ready=0 throughout.
   - On rsp_ready=1, req3 is accepted in the same cycle and rsp_id=3 follows with no bubble.
5. Overflow and wrap:
   - Add 0x7FFFFFFF+1 -> data=0x80000000, ovf=1, carry=0.
   - Add 0xFFFFFFFF+1 -> data=0, carry=1, ovf=0.
6. Reset mid-operation: rst=1 while rsp_valid=1 and a request is pending -> next cycle rsp_valid=0, op_count=0, pointer=0. After rst drops, with req1 and req3 both valid, req1 is granted first.

Source files
------------

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter in front of one shared W-bit add/subtract datapath.
// N requesters compete with valid/ready; the winner's operands go through
// a single (W+1)-bit adder into a one-deep result register with backpressure.
module addsub_arbiter #(
  parameter int N   = 4,
  parameter int W   = 32,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [N-1:0]     req_op,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  output logic [N-1:0]     req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_data,
  output logic [IDW-1:0]   rsp_id,
  output logic             rsp_carry,
  output logic             rsp_ovf,
  output logic [31:0]      op_count
);

  // Per-requester operand views of the packed buses.
  logic [N-1:0][W-1:0] a_lane, b_lane;
  assign a_lane = req_a;
  assign b_lane = req_b;

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           vld_q, vld_d;
  logic [W-1:0]   data_q, data_d;
  logic [IDW-1:0] id_q, id_d;
  logic           carry_q, carry_d;
  logic           ovf_q, ovf_d;
  logic [31:0]    cnt_q, cnt_d;

  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic           slot_free;
  logic           accept;

  // Scan req_valid from the pointer upward, wrapping; first set bit wins.
  always_comb begin : grant_scan
    int j;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      if (!gnt_found && req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(j);
      end
    end
  end

  // The result slot can take a new op when empty or being drained this cycle.
  assign slot_free = !vld_q || rsp_ready;
  assign accept    = gnt_found && slot_free && !rst;

  // Ready goes only to the granted requester; reset forces it low.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  // Shared adder: subtract is A + ~B + 1, so op drives both B inversion and carry-in.
  logic           op_sel;
  logic [W-1:0]   a_sel, b_sel;
  logic [W:0]     sum;
  logic           ovf_sel;
  assign op_sel  = req_op[gnt_idx];
  assign a_sel   = a_lane[gnt_idx];
  assign b_sel   = op_sel ? ~b_lane[gnt_idx] : b_lane[gnt_idx];
  assign sum     = {1'b0, a_sel} + {1'b0, b_sel} + (W+1)'(op_sel);
  assign ovf_sel = (a_sel[W-1] == b_sel[W-1]) && (sum[W-1] != a_sel[W-1]);

  // Next-state: load on accept, drop valid when drained, otherwise hold.
  always_comb begin
    ptr_d   = ptr_q;
    vld_d   = vld_q;
    data_d  = data_q;
    id_d    = id_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (accept) begin
      vld_d   = 1'b1;
      data_d  = sum[W-1:0];
      id_d    = gnt_idx;
      carry_d = sum[W];
      ovf_d   = ovf_sel;
      cnt_d   = cnt_q + 32'd1;
      ptr_d   = (gnt_idx == IDW'(N-1)) ? '0 : gnt_idx + IDW'(1);
    end else if (rsp_ready) begin
      vld_d   = 1'b0;
    end
  end

  // State registers with synchronous reset; a pending result is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      id_q    <= id_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_valid = vld_q;
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign rsp_carry = carry_q;
  assign rsp_ovf   = ovf_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: a negedge monitor keeps a reference model
// (grant pointer, valid, count) and a queue of expected results; scenario
// tasks add directed checks from the test plan.
module tb_addsub_arbiter;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_op;
  logic [N*W-1:0]   req_a, req_b;
  logic [N-1:0]     req_ready;
  logic             rsp_valid, rsp_ready;
  logic [W-1:0]     rsp_data;
  logic [IDW-1:0]   rsp_id;
  logic             rsp_carry, rsp_ovf;
  logic [31:0]      op_count;

  addsub_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0]   d;
    logic [IDW-1:0] id;
    logic           c;
    logic           o;
  } exp_t;
  exp_t sb[$];

  // Reference model state, mirrors what the DUT should hold before each edge.
  bit          mon_en = 1'b0;
  bit          mv = 1'b0;
  int          ptr_m = 0;
  logic [31:0] cnt_m = '0;

  function automatic int exp_grant(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic exp_t model_op(int g, logic op, logic [W-1:0] a, logic [W-1:0] b);
    exp_t e;
    longint ua, ub, sa, sbb, r;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'(signed'(a));
    sbb = longint'(signed'(b));
    if (op) begin
      e.d = a - b;
      e.c = (ua >= ub);
      r   = sa - sbb;
    end else begin
      e.d = a + b;
      e.c = ((ua + ub) >= (64'sd1 <<< W));
      r   = sa + sbb;
    end
    e.o  = (r > ((64'sd1 <<< (W-1)) - 1)) || (r < -(64'sd1 <<< (W-1)));
    e.id = IDW'(g);
    return e;
  endfunction

  // Monitor: compare DUT to model, then advance the model across the next edge.
  always @(negedge clk) begin
    if (mon_en) begin
      int g;
      logic [N-1:0] exp_rr;
      exp_t e;
      g = exp_grant(req_valid, ptr_m);
      exp_rr = '0;
      if (!rst && (!mv || rsp_ready) && g >= 0) exp_rr[g] = 1'b1;
      checks++;
      if (req_ready !== exp_rr) begin
        failures++;
        $display("FAIL mon_req_ready got %b exp %b at %0t", req_ready, exp_rr, $time);
      end
      checks++;
      if (rsp_valid !== mv) begin
        failures++;
        $display("FAIL mon_rsp_valid got %b exp %b at %0t", rsp_valid, mv, $time);
      end
      checks++;
      if (op_count !== cnt_m) begin
        failures++;
        $display("FAIL mon_op_count got %0d exp %0d at %0t", op_count, cnt_m, $time);
      end
      if (mv) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_empty rsp_valid with no expected result at %0t", $time);
        end else if (rsp_data !== sb[0].d || rsp_id !== sb[0].id ||
                     rsp_carry !== sb[0].c || rsp_ovf !== sb[0].o) begin
          failures++;
          $display("FAIL sb_result got d=%h id=%0d c=%b o=%b exp d=%h id=%0d c=%b o=%b at %0t",
                   rsp_data, rsp_id, rsp_carry, rsp_ovf,
                   sb[0].d, sb[0].id, sb[0].c, sb[0].o, $time);
        end
      end
      if (rst) begin
        sb.delete();
        mv = 1'b0; ptr_m = 0; cnt_m = '0;
      end else begin
        if (mv && rsp_ready && sb.size() > 0) void'(sb.pop_front());
        if ((!mv || rsp_ready) && g >= 0) begin
          e = model_op(g, req_op[g], req_a[g*W +: W], req_b[g*W +: W]);
          sb.push_back(e);
          mv = 1'b1;
          ptr_m = (g + 1) % N;
          cnt_m = cnt_m + 32'd1;
        end else if (rsp_ready) begin
          mv = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic op, logic [W-1:0] a, logic [W-1:0] b);
    req_valid[i] = 1'b1;
    req_op[i] = op;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic clr_req();
    req_valid = '0;
  endtask

  task automatic chk_rsp(string nm, logic [W-1:0] d, logic [IDW-1:0] id, logic c, logic o);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_id !== id || rsp_carry !== c || rsp_ovf !== o) begin
      failures++;
      $display("FAIL %s got v=%b d=%h id=%0d c=%b o=%b exp v=1 d=%h id=%0d c=%b o=%b",
               nm, rsp_valid, rsp_data, rsp_id, rsp_carry, rsp_ovf, d, id, c, o);
    end
  endtask

  task automatic chk_cnt(string nm, logic [31:0] exp);
    checks++;
    if (op_count !== exp) begin
      failures++;
      $display("FAIL %s op_count got %0d exp %0d", nm, op_count, exp);
    end
  endtask

  task automatic chk_rr(string nm, logic [N-1:0] exp);
    checks++;
    if (req_ready !== exp) begin
      failures++;
      $display("FAIL %s req_ready got %b exp %b", nm, req_ready, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_ready = 1'b1;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    step(); step();
    mon_en = 1'b1;
    set_req(0, 1'b0, 32'd0, 32'd0);
    #1;
    chk_rr("reset_ready_low", '0);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0 ||
        rsp_carry !== 1'b0 || rsp_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b d=%h id=%0d c=%b o=%b exp all zero",
               rsp_valid, rsp_data, rsp_id, rsp_carry, rsp_ovf);
    end
    chk_cnt("reset_count", 32'd0);
    clr_req();
    rst = 1'b0;
  endtask

  task automatic test_single_add();
    set_req(0, 1'b0, 32'h5, 32'h3);
    step(); clr_req();
    chk_rsp("single_add", 32'h8, 2'd0, 1'b0, 1'b0);
    chk_cnt("single_add", 32'd1);
  endtask

  task automatic test_subtract();
    set_req(2, 1'b1, 32'd3, 32'd5);
    step(); clr_req();
    chk_rsp("sub_borrow", 32'hFFFF_FFFE, 2'd2, 1'b0, 1'b0);
    set_req(2, 1'b1, 32'h8000_0000, 32'd1);
    step(); clr_req();
    chk_rsp("sub_ovf", 32'h7FFF_FFFF, 2'd2, 1'b1, 1'b1);
    chk_cnt("subtract", 32'd3);
  endtask

  task automatic test_round_robin();
    // Pointer sits at 3 after the subtracts; one op from req3 brings it to 0.
    set_req(3, 1'b0, 32'd1, 32'd1);
    step(); clr_req();
    chk_rsp("rr_align", 32'd2, 2'd3, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'(i * 16 + 1), 32'(i));
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== IDW'(k % N)) begin
        failures++;
        $display("FAIL rr_seq[%0d] got v=%b id=%0d exp v=1 id=%0d", k, rsp_valid, rsp_id, k % N);
      end
    end
    clr_req();
    chk_cnt("round_robin", 32'd12);
  endtask

  task automatic test_backpressure();
    set_req(1, 1'b0, 32'h100, 32'h23);
    step(); clr_req();
    rsp_ready = 1'b0;
    set_req(3, 1'b1, 32'd50, 32'd8);
    #1;
    chk_rr("bp_ready_low", '0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_rsp($sformatf("bp_stall[%0d]", k), 32'h123, 2'd1, 1'b0, 1'b0);
      chk_rr($sformatf("bp_stall_ready[%0d]", k), '0);
    end
    rsp_ready = 1'b1;
    #1;
    chk_rr("bp_release_ready", 4'b1000);
    step(); clr_req();
    chk_rsp("bp_no_bubble", 32'd42, 2'd3, 1'b1, 1'b0);
    step();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'd42) begin
      failures++;
      $display("FAIL bp_drain got v=%b d=%h exp v=0 d=0000002a", rsp_valid, rsp_data);
    end
    chk_cnt("backpressure", 32'd14);
  endtask

  task automatic test_overflow_wrap();
    set_req(0, 1'b0, 32'h7FFF_FFFF, 32'd1);
    step(); clr_req();
    chk_rsp("add_ovf", 32'h8000_0000, 2'd0, 1'b0, 1'b1);
    set_req(1, 1'b0, 32'hFFFF_FFFF, 32'd1);
    step(); clr_req();
    chk_rsp("add_wrap", 32'h0, 2'd1, 1'b1, 1'b0);
    chk_cnt("overflow_wrap", 32'd16);
  endtask

  task automatic test_reset_mid();
    step();
    rsp_ready = 1'b0;
    set_req(2, 1'b0, 32'd10, 32'd20);
    step();
    chk_rsp("rmid_pending", 32'd30, 2'd2, 1'b0, 1'b0);
    rst = 1'b1; rsp_ready = 1'b1;
    #1;
    chk_rr("rmid_ready_in_reset", '0);
    step();
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0) begin
      failures++;
      $display("FAIL rmid_cleared got v=%b d=%h id=%0d exp v=0 d=0 id=0", rsp_valid, rsp_data, rsp_id);
    end
    chk_cnt("rmid_count", 32'd0);
    clr_req();
    set_req(1, 1'b0, 32'd7, 32'd7);
    set_req(3, 1'b0, 32'd9, 32'd9);
    #1;
    chk_rr("rmid_ptr0_grant", 4'b0010);
    step(); clr_req();
    chk_rsp("rmid_first", 32'd14, 2'd1, 1'b0, 1'b0);
    chk_cnt("rmid_after", 32'd1);
    step(); step();
  endtask

  initial begin
    if (IDW != $clog2(N)) begin
      $display("FAIL idw_param IDW=%0d exp clog2(N)=%0d", IDW, $clog2(N));
      $fatal(1);
    end
    test_reset();
    test_single_add();
    test_subtract();
    test_round_robin();
    test_backpressure();
    test_overflow_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
